// File: rtl/uart_loader_pkg.sv
// rtl/uart_loader_pkg.sv - shared types and constants for the UART program loader
package uart_loader_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_ADDR_HI = 3'd1;
    localparam state_t ST_ADDR_LO = 3'd2;
    localparam state_t ST_LEN_HI  = 3'd3;
    localparam state_t ST_LEN_LO  = 3'd4;
    localparam state_t ST_DATA_HI = 3'd5;
    localparam state_t ST_DATA_LO = 3'd6;
    localparam state_t ST_CHECK   = 3'd7;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CHK     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    function automatic logic [7:0] chk_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/uart_loader_if.sv
// rtl/uart_loader_if.sv - receiver byte input and memory write/status bundle of the loader
interface uart_loader_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;
    logic [1:0]        err_code;

    modport master (
        output rx_data, rx_ready,
        input  mem_addr, mem_wdata, mem_we, cpu_hold, load_done, load_err, err_code
    );

    modport slave (
        input  rx_data, rx_ready,
        output mem_addr, mem_wdata, mem_we, cpu_hold, load_done, load_err, err_code
    );
endinterface

// File: rtl/uart_loader_rise_pulse.sv
// rtl/uart_loader_rise_pulse.sv - 2-flop synchroniser with rising-edge pulse
module rise_pulse (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic pulse_o
);
    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Chain resets high so a level already high at reset exit is not seen as an edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= sig_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign pulse_o = sync_q & ~prev_q;
endmodule

// File: rtl/uart_loader.sv
// rtl/uart_loader.sv - parses framed load packets from the UART and writes words to memory
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int          ADDR_W       = 16,
    parameter int          DATA_W       = 16,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEF,
    parameter int unsigned TIMEOUT_CLKS = 5000000
) (
    input logic         clk,
    input logic         rst,
    uart_loader_if.slave ldr
);
    localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);

    logic       byte_stb;
    logic [7:0] rx_byte;
    logic       tmo_expired;

    state_t            state_q, state_d;
    logic [7:0]        addr_hi_q, addr_hi_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [15:0]       remaining_q, remaining_d;
    logic [7:0]        data_hi_q, data_hi_d;
    logic [7:0]        chk_q, chk_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              load_done_q, load_done_d;
    logic              load_err_q, load_err_d;
    logic [1:0]        err_code_q, err_code_d;

    rise_pulse u_rise (
        .clk     (clk),
        .rst     (rst),
        .sig_i   (ldr.rx_ready),
        .pulse_o (byte_stb)
    );

    assign rx_byte = ldr.rx_data;

    // A byte arriving in the expiry cycle takes priority over the timeout.
    assign tmo_expired = (state_q != ST_IDLE) && !byte_stb && (tmo_q == TMO_LAST);

    always_comb begin
        state_d     = state_q;
        addr_hi_d   = addr_hi_q;
        addr_d      = addr_q;
        len_hi_d    = len_hi_q;
        remaining_d = remaining_q;
        data_hi_d   = data_hi_q;
        chk_d       = chk_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        cpu_hold_d  = cpu_hold_q;
        load_done_d = 1'b0;
        load_err_d  = load_err_q;
        err_code_d  = err_code_q;

        if (state_q == ST_IDLE || byte_stb) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end

        if (byte_stb && state_q != ST_IDLE && state_q != ST_CHECK) begin
            chk_d = chk_step(chk_q, rx_byte);
        end

        if (byte_stb) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_byte == SYNC_BYTE) begin
                        state_d    = ST_ADDR_HI;
                        cpu_hold_d = 1'b1;
                        load_err_d = 1'b0;
                        err_code_d = ERR_NONE;
                        chk_d      = '0;
                    end
                end
                ST_ADDR_HI: begin
                    addr_hi_d = rx_byte;
                    state_d   = ST_ADDR_LO;
                end
                ST_ADDR_LO: begin
                    addr_d  = ADDR_W'({addr_hi_q, rx_byte});
                    state_d = ST_LEN_HI;
                end
                ST_LEN_HI: begin
                    len_hi_d = rx_byte;
                    state_d  = ST_LEN_LO;
                end
                ST_LEN_LO: begin
                    remaining_d = {len_hi_q, rx_byte};
                    state_d     = ({len_hi_q, rx_byte} != 16'd0) ? ST_DATA_HI : ST_CHECK;
                end
                ST_DATA_HI: begin
                    data_hi_d = rx_byte;
                    state_d   = ST_DATA_LO;
                end
                ST_DATA_LO: begin
                    mem_addr_d  = addr_q;
                    mem_wdata_d = DATA_W'({data_hi_q, rx_byte});
                    mem_we_d    = 1'b1;
                    addr_d      = addr_q + 1'b1;
                    remaining_d = remaining_q - 16'd1;
                    state_d     = (remaining_q == 16'd1) ? ST_CHECK : ST_DATA_HI;
                end
                ST_CHECK: begin
                    if (rx_byte == chk_q) begin
                        load_done_d = 1'b1;
                        cpu_hold_d  = 1'b0;
                    end else begin
                        load_err_d = 1'b1;
                        err_code_d = ERR_CHK;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (tmo_expired) begin
            load_err_d = 1'b1;
            err_code_d = ERR_TIMEOUT;
            state_d    = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            addr_hi_q   <= '0;
            addr_q      <= '0;
            len_hi_q    <= '0;
            remaining_q <= '0;
            data_hi_q   <= '0;
            chk_q       <= '0;
            tmo_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            cpu_hold_q  <= 1'b0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            addr_hi_q   <= addr_hi_d;
            addr_q      <= addr_d;
            len_hi_q    <= len_hi_d;
            remaining_q <= remaining_d;
            data_hi_q   <= data_hi_d;
            chk_q       <= chk_d;
            tmo_q       <= tmo_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            cpu_hold_q  <= cpu_hold_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign ldr.mem_addr  = mem_addr_q;
    assign ldr.mem_wdata = mem_wdata_q;
    assign ldr.mem_we    = mem_we_q;
    assign ldr.cpu_hold  = cpu_hold_q;
    assign ldr.load_done = load_done_q;
    assign ldr.load_err  = load_err_q;
    assign ldr.err_code  = err_code_q;
endmodule

// File: tb/tb_uart_loader.sv
// tb/tb_uart_loader.sv - scoreboard testbench for uart_loader
module tb_uart_loader;
    localparam int TMO = 1000;

    logic clk = 1'b0;
    logic rst = 1'b0;

    uart_loader_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    uart_loader #(
        .ADDR_W       (16),
        .DATA_W       (16),
        .SYNC_BYTE    (8'hA5),
        .TIMEOUT_CLKS (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ldr (bus.slave)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          exp_done = 0;
    logic [31:0] exp_wr_q[$];
    logic [15:0] words_q[$];
    logic [31:0] exp_wr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Each byte: ready high for 4 edges, low for 4 edges; starts and ends at posedge+1.
    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 bus.rx_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Sends a full frame of words_q to addr and pushes the expected writes/done.
    task automatic send_frame(input logic [15:0] addr, input bit corrupt);
        logic [7:0]  chk;
        logic [15:0] len;
        logic [15:0] a;
        len = 16'(words_q.size());
        chk = addr[15:8] ^ addr[7:0] ^ len[15:8] ^ len[7:0];
        a = addr;
        foreach (words_q[i]) begin
            chk = chk ^ words_q[i][15:8] ^ words_q[i][7:0];
            exp_wr_q.push_back({a, words_q[i]});
            a = a + 16'd1;
        end
        if (!corrupt) exp_done++;
        send_byte(8'hA5);
        send_byte(addr[15:8]);
        send_byte(addr[7:0]);
        send_byte(len[15:8]);
        send_byte(len[7:0]);
        foreach (words_q[i]) begin
            send_byte(words_q[i][15:8]);
            send_byte(words_q[i][7:0]);
        end
        send_byte(corrupt ? (chk ^ 8'h13) : chk);
        words_q.delete();
    endtask

    task automatic check_status(input string tag, input logic hold, input logic err, input logic [1:0] code);
        check({tag, "_cpu_hold"}, 32'(bus.cpu_hold), 32'(hold));
        check({tag, "_load_err"}, 32'(bus.load_err), 32'(err));
        check({tag, "_err_code"}, 32'(bus.err_code), 32'(code));
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (bus.mem_we === 1'b1) begin
                checks++;
                if (exp_wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write addr=%h data=%h expected=none", bus.mem_addr, bus.mem_wdata);
                end else begin
                    exp_wr = exp_wr_q.pop_front();
                    if ({bus.mem_addr, bus.mem_wdata} !== exp_wr) begin
                        errors++;
                        $display("FAIL write actual=%h_%h expected=%h_%h", bus.mem_addr, bus.mem_wdata,
                                 exp_wr[31:16], exp_wr[15:0]);
                    end
                end
                checks++;
                if (bus.cpu_hold !== 1'b1) begin
                    errors++;
                    $display("FAIL hold_during_write actual=%b expected=1", bus.cpu_hold);
                end
            end
            if (bus.load_done === 1'b1) begin
                checks++;
                if (exp_done == 0) begin
                    errors++;
                    $display("FAIL unexpected_done actual=1 expected=0");
                end else begin
                    exp_done--;
                end
                checks++;
                if (bus.cpu_hold !== 1'b0) begin
                    errors++;
                    $display("FAIL hold_at_done actual=%b expected=0", bus.cpu_hold);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with rx_ready already high and a SYNC value on the bus.
        bus.rx_data  = 8'hA5;
        bus.rx_ready = 1'b1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        check("rst_mem_we", 32'(bus.mem_we), 0);
        check("rst_mem_addr", 32'(bus.mem_addr), 0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 0);
        check("rst_load_done", 32'(bus.load_done), 0);
        check_status("rst", 1'b0, 1'b0, 2'd0);
        repeat (10) @(posedge clk);
        #1 check("ready_high_no_strobe_hold", 32'(bus.cpu_hold), 0);
        bus.rx_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Non-sync bytes while idle are ignored.
        send_byte(8'h55);
        send_byte(8'h00);
        check("idle_junk_hold", 32'(bus.cpu_hold), 0);

        // Basic two-word frame.
        words_q = '{16'h1234, 16'hABCD};
        send_frame(16'h0010, 1'b0);
        check_status("frame1", 1'b0, 1'b0, 2'd0);

        // Address wraps FFFF -> 0000; SYNC value as data is not a restart.
        words_q = '{16'h0001, 16'h00A5};
        send_frame(16'hFFFF, 1'b0);
        check_status("wrap", 1'b0, 1'b0, 2'd0);

        // Bad checksum: writes still land, error is sticky, hold stays.
        words_q = '{16'h1234, 16'hABCD};
        send_frame(16'h0010, 1'b1);
        check_status("badchk", 1'b1, 1'b1, 2'd1);
        words_q = '{16'h5A5A};
        send_frame(16'h0100, 1'b0);
        check_status("recover", 1'b0, 1'b0, 2'd0);

        // Zero-length frame.
        send_frame(16'h0020, 1'b0);
        check_status("len0", 1'b0, 1'b0, 2'd0);

        // Silence inside a frame times out.
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h10);
        repeat (TMO + 100) @(posedge clk);
        #1 check_status("timeout", 1'b1, 1'b1, 2'd2);

        // Next byte's strobe lands exactly in the expiry cycle: accepted.
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h10);
        repeat (TMO - 8) @(posedge clk);
        #1;
        exp_done++;
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h10);
        check_status("at_expiry", 1'b0, 1'b0, 2'd0);

        // One cycle later the timeout wins and the late byte is ignored.
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h10);
        repeat (TMO - 7) @(posedge clk);
        #1;
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h10);
        check_status("past_expiry", 1'b1, 1'b1, 2'd2);

        // Reset mid data phase: no write, no error, all outputs cleared.
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h10);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h12);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_mem_we", 32'(bus.mem_we), 0);
        check("midrst_mem_addr", 32'(bus.mem_addr), 0);
        check("midrst_load_done", 32'(bus.load_done), 0);
        check_status("midrst", 1'b0, 1'b0, 2'd0);
        send_byte(8'h34);
        send_byte(8'hAB);
        send_byte(8'hCD);
        check_status("after_midrst", 1'b0, 1'b0, 2'd0);

        repeat (20) @(posedge clk);
        #1;
        check("writes_outstanding", 32'(exp_wr_q.size()), 0);
        check("done_outstanding", 32'(exp_done), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
